// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a parameterised reset value; 2-cycle latency, no backpressure.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// UART-style frame deserialiser (start, 8 data LSB first, parity, stop) feeding a parity checker.
// Strobe lands one cycle after the mid-stop sample; no backpressure, check/frame_err are fire-and-forget.
module serial_frame_receiver
  import serial_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_bit,
  output logic                 check,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] sh;
  logic                 par;

  // Idle-high reset value keeps the line from looking like a start bit out of reset.
  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      par        <= 1'b0;
      data       <= '0;
      parity_bit <= 1'b0;
      check      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      check     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          // Half-bit delay aligns every later sample to mid-bit.
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            sh[idx] <= rx_s;
            cnt     <= '0;
            if (idx == IDX_LAST) state <= PARITY;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == BIT_LAST) begin
            par   <= rx_s;
            cnt   <= '0;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop lets a start bit right behind the stop bit be caught.
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              data       <= sh;
              parity_bit <= par;
              check      <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench: stimulus queues expected strobes, a negedge monitor pops and compares.
module tb_serial_frame_receiver;

  localparam int N = 4;
  localparam int H = N / 2;
  localparam int FRAME = 11 * N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       parity_bit;
  logic       check;
  logic       frame_err;
  logic       busy;

  serial_frame_receiver #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .parity_bit(parity_bit),
    .check     (check),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] d;
    logic       p;
    int         gap;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_strobe = 0;
  logic [7:0] last_good = 8'h00;
  logic       last_par = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (check || frame_err)) begin
      exp_t e;
      chk("strobe_exclusive", {31'd0, check & frame_err}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe check=%0b frame_err=%0b data=%0h", check, frame_err, data);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
        chk("data", {24'd0, data}, {24'd0, e.d});
        chk("parity_bit", {31'd0, parity_bit}, {31'd0, e.p});
        if (e.gap >= 0) chk("strobe_gap", cyc - last_strobe, e.gap);
      end
      last_strobe = cyc;
    end
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic p, input logic s);
    drive(1'b0, N);
    for (int i = 0; i < 8; i++) drive(b[i], N);
    drive(p, N);
    drive(s, N);
  endtask

  // Expected outcome of one frame: good stop latches the byte, bad stop reports the held byte.
  task automatic expect_frame(input logic [7:0] b, input logic p, input logic s, input int gap);
    exp_t e;
    if (s) begin
      last_good = b;
      last_par  = p;
    end
    e.err = !s;
    e.d   = last_good;
    e.p   = last_par;
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Line low for L cycles then high: attempts restart every H+10N+1 cycles while the line is low.
  task automatic expect_held_low(input int L);
    int         s;
    logic [7:0] b;
    logic       p;
    s = 0;
    while (s < L) begin
      if (s + H >= L) break;
      for (int i = 0; i < 8; i++) b[i] = (s + H + (i + 1) * N >= L);
      p = (s + H + 9 * N >= L);
      if (s + H + 10 * N < L) begin
        expect_frame(b, p, 1'b0, -1);
        s = s + H + 10 * N + 1;
      end else begin
        expect_frame(b, p, 1'b1, -1);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int         bc;
    int         prev_idle;
    logic [7:0] rb;
    logic       rp;
    logic       rs;
    int         idle;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'h00);
    chk("reset_parity", {31'd0, parity_bit}, 32'd0);
    chk("reset_check", {31'd0, check}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    drive(1'b1, 5);

    expect_frame(8'h01, 1'b1, 1'b1, -1);
    send(8'h01, 1'b1, 1'b1);
    drive(1'b1, 6);

    expect_frame(8'h41, 1'b0, 1'b1, -1);
    expect_frame(8'hFF, 1'b0, 1'b1, FRAME);
    send(8'h41, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    drive(1'b1, 6);

    drive(1'b0, 1);
    rx = 1'b1;
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("glitch_busy_cycles", bc, H);

    expect_frame(8'h31, 1'b1, 1'b0, -1);
    send(8'h31, 1'b1, 1'b0);
    drive(1'b1, N + 4);

    drive(1'b0, N);
    for (int i = 0; i < 4; i++) drive(rb_bit(8'h37, i), N);
    drive(1'b1, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_data", {24'd0, data}, 32'h00);
    chk("midreset_parity", {31'd0, parity_bit}, 32'd0);
    chk("midreset_check", {31'd0, check}, 32'd0);
    chk("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    last_good = 8'h00;
    last_par  = 1'b0;
    drive(1'b1, 6);
    expect_frame(8'hF1, 1'b1, 1'b1, -1);
    send(8'hF1, 1'b1, 1'b1);
    drive(1'b1, 6);

    expect_held_low(100);
    drive(1'b0, 100);
    drive(1'b1, 60);
    expect_frame(8'h00, 1'b0, 1'b1, -1);
    send(8'h00, 1'b0, 1'b1);
    drive(1'b1, 6);

    prev_idle = -1;
    for (int k = 0; k < 24; k++) begin
      rb   = 8'($urandom_range(0, 255));
      rp   = 1'($urandom_range(0, 1));
      rs   = ($urandom_range(0, 4) != 0);
      idle = $urandom_range(0, 3) + (rs ? 0 : N);
      expect_frame(rb, rp, rs, (prev_idle < 0) ? -1 : FRAME + prev_idle);
      send(rb, rp, rs);
      drive(1'b1, idle);
      prev_idle = idle;
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
